// File: rtl/pwm_param_calc.sv
// pwm_param_calc: turns frequency/duty settings into 64 MHz tick counts for the switch controller,
// using one shared restoring divider and publishing the period/duty pair atomically.
module pwm_param_calc #(
   parameter int CLK_HZ   = 64_000_000,
   parameter int FREQ_MIN = 50,
   parameter int FREQ_MAX = 50_000
) (
   input  logic        clk64_i,
   input  logic        rstn_i,
   input  logic        cfg_valid_i,
   input  logic [15:0] freq_hz_i,
   input  logic [9:0]  duty_pm_i,
   output logic [20:0] period_count_o,
   output logic [20:0] duty_count_o,
   output logic        upd_o,
   output logic        busy_o,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, CHK, DIV_P, MUL, DIV_D, DONE} state_t;
   localparam logic [25:0] CLK26 = CLK_HZ[25:0];
   localparam logic [15:0] FMIN  = FREQ_MIN[15:0];
   localparam logic [15:0] FMAX  = FREQ_MAX[15:0];
   state_t      r_state, w_next;
   logic        r_pend;
   logic [15:0] r_pfreq, r_freq, r_rem, r_den;
   logic [9:0]  r_pduty, r_duty;
   logic [30:0] r_num;
   logic [4:0]  r_cnt;
   logic [20:0] r_period;
   logic [16:0] w_sh;
   logic        w_q, w_range_ok;
   assign busy_o = (r_state != IDLE);
   always_comb begin
      w_sh       = {r_rem, r_num[30]};
      w_q        = (w_sh >= {1'b0, r_den});
      w_range_ok = (r_freq >= FMIN) && (r_freq <= FMAX);
      w_next     = r_state;
      case (r_state)
         IDLE:    w_next = (r_pend || cfg_valid_i) ? CHK : IDLE;
         CHK:     w_next = w_range_ok ? DIV_P : IDLE;
         DIV_P:   w_next = (r_cnt == 5'd0) ? MUL : DIV_P;
         MUL:     w_next = DIV_D;
         DIV_D:   w_next = (r_cnt == 5'd0) ? DONE : DIV_D;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk64_i or negedge rstn_i)
      if (!rstn_i) r_state <= IDLE;
      else         r_state <= w_next;
   always_ff @(posedge clk64_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pend         <= 1'b0;
         r_pfreq        <= '0;
         r_pduty        <= '0;
         r_freq         <= '0;
         r_duty         <= '0;
         r_num          <= '0;
         r_rem          <= '0;
         r_den          <= '0;
         r_cnt          <= '0;
         r_period       <= '0;
         period_count_o <= '0;
         duty_count_o   <= '0;
         upd_o          <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         upd_o <= 1'b0;
         // a strobe that cannot be taken now (busy, or pending already queued) becomes the new pending
         if (cfg_valid_i && (r_state != IDLE || r_pend)) begin
            r_pend  <= 1'b1;
            r_pfreq <= freq_hz_i;
            r_pduty <= duty_pm_i;
         end else if (r_state == IDLE && r_pend) begin
            r_pend <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_freq <= r_pend ? r_pfreq : freq_hz_i;
               r_duty <= r_pend ? r_pduty : duty_pm_i;
            end
            CHK: begin
               err_o  <= !w_range_ok;
               r_duty <= (r_duty > 10'd1000) ? 10'd1000 : r_duty;
               r_num  <= {CLK26, 5'd0};
               r_rem  <= '0;
               r_den  <= r_freq;
               r_cnt  <= 5'd25;
            end
            DIV_P, DIV_D: begin
               r_num <= {r_num[29:0], w_q};
               r_rem <= w_q ? 16'(w_sh - {1'b0, r_den}) : w_sh[15:0];
               r_cnt <= r_cnt - 5'd1;
            end
            MUL: begin
               r_period <= r_num[20:0];
               r_num    <= {10'd0, r_num[20:0]} * {21'd0, r_duty};
               r_rem    <= '0;
               r_den    <= 16'd1000;
               r_cnt    <= 5'd30;
            end
            DONE: begin
               period_count_o <= r_period;
               duty_count_o   <= r_num[20:0];
               upd_o          <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
